// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - fetch-stage types and constants shared by the FIFO and top
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif

package inst_fetch_unit_pkg;

    localparam int XLEN = `XLEN;
    localparam logic [XLEN-1:0] RESET_VECTOR = `RESET_VECTOR;
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/define.v
// rtl/define.v - shared fetch-path constants (XLEN, reset vector, canonical NOP)
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// rtl/inst_fetch_unit_fetch_fifo.sv - in-order {inst, pc} buffer with single-cycle flush
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  fifo_entry_t       push_entry,
    input  logic              pop,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output fifo_entry_t       head_entry
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t       mem_q [DEPTH];
    fifo_entry_t       mem_d [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_entry;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count      = count_q;
    assign head_entry = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, credit-limited imem requests, squash on redirect
// FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_drop, push, pop;
    logic [31:0]   redirect_target;
    fifo_entry_t   head_entry;

    assign redirect_target = redirect_pc & WORD_MASK;
    assign credit_used     = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem_req_valid  = !rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr   = fetch_pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // A response is stale if older redirects still owe discards, or it lands in a redirect cycle.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (discard_q != '0));
    assign push     = imem_rsp_valid && !rsp_drop;
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end
        if (push) begin
            rsp_pc_d = pc_next(rsp_pc_q);
        end
        if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            discard_d  = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{inst: imem_rsp_data, pc: rsp_pc_q}),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_entry (head_entry)
    );

    assign inst_valid    = (fifo_count != '0);
    assign inst          = head_entry.inst;
    assign inst_pc       = head_entry.pc;
    assign inst_pc_plus4 = inst_valid ? pc_next(head_entry.pc) : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q + 32'(pop);
        perf_squashed_d = perf_squashed_q + 32'(rsp_drop);
        if (redirect_valid) begin
            perf_squashed_d = perf_squashed_d + 32'(fifo_count) - 32'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed vectors plus scoreboard for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc, inst_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [6];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q_addr [$];
    bit          rsp_en;
    int          pops, accepts, pc40_pops;
    bit          wrap_seen;
    logic [31:0] exp_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: scoreboard the current cycle, then let the memory model present next cycle's response.
    task automatic cyc();
        #1;
        if (rst) q_addr.delete();
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            accepts++;
        end
        if (inst_valid === 1'b1 && inst_ready) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_inst", inst, word_of(exp_pc));
            check("pop_pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
            if (inst_pc == 32'h40) pc40_pops++;
            if (inst_pc_plus4 == 32'h0) wrap_seen = 1'b1;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        @(negedge clk);
        if (!rst && rsp_en && q_addr.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(q_addr.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        cyc();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_pc_plus4", inst_pc_plus4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_squashed", perf_squashed, 32'd0);
`endif
        cyc();
        rst     = 1'b0;
        exp_pc  = 32'h0;
        pops    = 0;
        accepts = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        rsp_en         = 1'b1;
        exp_pc         = '0;
        @(negedge clk);
        do_reset();

        // Streaming from RESET_PC with a 1-cycle memory.
        for (int i = 0; i < 6; i++) begin
            inst_ready = tbl[i].ready;
            #1;
            check("stream_req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) check("stream_req_addr", imem_req_addr, tbl[i].addr);
            check("stream_inst_valid", 32'(inst_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) check("stream_inst_pc", inst_pc, tbl[i].pc);
            cyc();
        end

        // Backpressure: credit limit holds and fills exactly.
        inst_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("bp_credit", 32'((accepts - pops) <= DEPTH), 32'd1);
        end
        check("bp_credit_full", 32'(accepts - pops), 32'(DEPTH));
        #1;
        check("bp_req_blocked", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        run(12);

        // Redirect with responses still pending in memory.
        rsp_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (q_addr.size() >= 2) break;
            cyc();
        end
        check("pending_before_redirect", 32'(q_addr.size() >= 2), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        begin
            int p0;
            p0 = pops;
            run(15);
            check("after_redirect_progress", 32'((pops - p0) >= 4), 32'd1);
        end

        // Branch at 0x40 popped in the redirect cycle; 0x44 and later flushed.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        pc40_pops      = 0;
        run(8);
        #1;
        check("branch_head_valid", 32'(inst_valid), 32'd1);
        check("branch_head_pc", inst_pc, 32'h40);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        run(10);
        check("branch_popped_once", 32'(pc40_pops), 32'd1);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        cyc();
        redirect_valid = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (imem_req_valid) begin
                    check("misaligned_addr", imem_req_addr, 32'h200);
                    found = 1'b1;
                    break;
                end
                cyc();
            end
            check("misaligned_req_seen", 32'(found), 32'd1);
        end
        run(8);

        // Address wrap at the top of memory.
        wrap_seen      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        run(10);
        check("wrap_plus4_zero_seen", 32'(wrap_seen), 32'd1);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (pops == 5) break;
            cyc();
        end
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_squashed", perf_squashed, 32'd2);
        inst_ready = 1'b1;
        run(6);
`endif

        // Reset in the middle of traffic.
        do_reset();
        run(6);
        check("post_reset_stream", 32'(pops >= 3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
